hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DIV_CYCLES, default 32, meaning: total stall cycles for one multi-cycle divide (range 2..63).
REQ-002 clk  input  1  single clock; every flop updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 rsD, rtD, rsE, rtE  input  5 each  source register numbers in the Decode and Execute stages.
REQ-005 writeregE, writeregM, writeregW  input  5 each  destination register numbers in the E, M and W stages.
REQ-006 regwriteE, regwriteM, regwriteW, memtoregE, memtoregM  input  1 each  control bits from the pipeline controller.
REQ-007 branchD  input  1  branch in Decode; operands compared in Decode.
REQ-008 div_startE  input  1  divide instruction in Execute.
REQ-009 excM  input  1  exception taken in Memory.
REQ-010 stallF, stallD, stallE, stallM, stallW  output  1 each  pipeline register hold enables.
REQ-011 flushD, flushE, flushM, flushW  output  1 each  pipeline register clear.
REQ-012 forwardAD, forwardBD  output  1 each  Decode comparator bypass from M.
REQ-013 forwardAE, forwardBE  output  2 each  Execute ALU operand select: 00 = register file, 01 = W result, 10 = M result.
REQ-014 div_busy, div_done  output  1 each  divider running; one-cycle completion pulse.

Function
REQ-015 Forwarding in E: forwardAE = 10 if rsE!=0, regwriteM=1 and writeregM==rsE; else 01 if rsE!=0, regwriteW=1 and writeregW==rsE; else 00. M wins when both match. forwardBE is identical using rtE.
REQ-016 forwardAD = (rsD!=0 & regwriteM & writeregM==rsD); forwardBD uses rtD the same way.
REQ-017 lwstall = memtoregE & ((rsD!=0 & rsD==writeregE) | (rtD!=0 & rtD==writeregE)).
REQ-018 branchstall = branchD & (regwriteE & writeregE matches nonzero rsD/rtD, or memtoregM & writeregM matches nonzero rsD/rtD).
REQ-019 The divide FSM has states IDLE and RUN, plus a 6-bit counter cnt.
REQ-020 IDLE with div_startE=1 and excM=0 -> RUN next cycle, cnt=0.
REQ-021 RUN with cnt<DIV_CYCLES-1 -> stay in RUN, cnt+1.
REQ-022 RUN with cnt==DIV_CYCLES-1 -> IDLE, cnt=0.
REQ-023 div_startE is ignored in RUN.
REQ-024 divstall = (IDLE & div_startE) | (RUN & cnt!=DIV_CYCLES-1). The divide therefore holds E for exactly DIV_CYCLES cycles.
REQ-025 div_busy = (state==RUN). div_done = RUN & cnt==DIV_CYCLES-1, a single-cycle pulse that is combinational from state.
REQ-026 Without an exception, the outputs are:
- stallF = stallD = lwstall | branchstall | divstall
- stallE = divstall
- flushE = (lwstall | branchstall) & ~divstall
- flushM = divstall
- stallM = stallW = flushD = flushW = 0
REQ-027 excM=1 overrides every other rule in the same cycle:
- all stall outputs 0
- flushD = flushE = flushM = flushW = 1
- FSM forced to IDLE with cnt=0 at the next edge, even mid-divide
REQ-028 A divide beginning while lwstall is active: divstall takes precedence, E is held, D/F are held, and no E bubble is inserted.
REQ-029 All stall, flush and forward outputs are combinational from the inputs and the FSM state; the only sequential elements are the FSM state and cnt.

Reset
REQ-030 resetn=0 asynchronously sets state=IDLE and cnt=0.
REQ-031 While resetn=0, div_busy=0 and div_done=0, and the remaining outputs follow REQ-015..REQ-029 with state IDLE.
REQ-032 Release of resetn takes effect at the next rising edge of clk.

Verification
REQ-033 Load-use: memtoregE=1, writeregE=5, rsD=5 -> stallF=stallD=1, flushE=1, stallE=0 for one cycle; with rsD=0 -> no stall.
REQ-034 Forward priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=7 -> forwardAE=10; with regwriteM=0 -> forwardAE=01; with rsE=0 -> 00.
REQ-035 Divide, DIV_CYCLES=32: pulse div_startE=1 held high -> stallE=1 for exactly 32 cycles, div_busy=1 for 32 cycles starting one cycle after start, div_done=1 only in the 32nd busy cycle, flushM=1 during each stalled cycle.
REQ-036 Exception mid-divide: excM=1 at cnt=10 -> that cycle all flushes=1 and all stalls=0; next cycle div_busy=0 and cnt=0.
REQ-037 Branch hazard: branchD=1, regwriteE=1, writeregE=rtD=3 -> stallD=1, flushE=1; next cycle with the producer in M and memtoregM=0 -> stall clears and forwardBD=1.
REQ-038 Async reset: assert resetn=0 between edges while in RUN -> div_busy drops immediately; after release, the first div_startE gives a full 32-cycle stall.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath/controller and the hazard unit.
// The master drives stage register numbers and control bits; the slave returns stall/flush/forward selects.
interface hazard_unit_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeregE;
  logic [4:0] writeregM;
  logic [4:0] writeregW;
  logic       regwriteE;
  logic       regwriteM;
  logic       regwriteW;
  logic       memtoregE;
  logic       memtoregM;
  logic       branchD;
  logic       div_startE;
  logic       excM;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       stallW;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       flushW;
  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       div_busy;
  logic       div_done;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    output branchD, div_startE, excM,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_done
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
    input  branchD, div_startE, excM,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_done
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch stalls,
// multi-cycle divide stall sequencing and exception flush.
module hazard_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         resetn,
  hazard_unit_if.slave hz
);
  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} div_state_t;

  div_state_t r_state;
  logic [5:0] r_cnt;
  logic       w_lwstall;
  logic       w_branchstall;
  logic       w_divstall;
  logic       w_last;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic dep(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic rw_m, input logic [4:0] dst_m,
                                         input logic rw_w, input logic [4:0] dst_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && dep(src, dst_m)) begin
      sel = 2'b10;
    end else if (rw_w && dep(src, dst_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection terms
  always_comb begin
    w_last        = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    w_lwstall     = hz.memtoregE & (dep(hz.rsD, hz.writeregE) | dep(hz.rtD, hz.writeregE));
    w_branchstall = hz.branchD &
                    ((hz.regwriteE & (dep(hz.rsD, hz.writeregE) | dep(hz.rtD, hz.writeregE))) |
                     (hz.memtoregM & (dep(hz.rsD, hz.writeregM) | dep(hz.rtD, hz.writeregM))));
    w_divstall    = ((r_state == S_IDLE) && hz.div_startE) ||
                    ((r_state == S_RUN) && (r_cnt != LAST_CNT));
  end

  // Stall, flush and forward selects
  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.stallW    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushM    = 1'b0;
    hz.flushW    = 1'b0;
    hz.forwardAE = fwd_sel(hz.rsE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
    hz.forwardBE = fwd_sel(hz.rtE, hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW);
    hz.forwardAD = hz.regwriteM & dep(hz.rsD, hz.writeregM);
    hz.forwardBD = hz.regwriteM & dep(hz.rtD, hz.writeregM);
    hz.div_busy  = (r_state == S_RUN);
    hz.div_done  = w_last;
    if (hz.excM) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
      hz.flushW = 1'b1;
    end else begin
      // A divide holds E itself, so no bubble is pushed into E while it runs.
      hz.stallF = w_lwstall | w_branchstall | w_divstall;
      hz.stallD = w_lwstall | w_branchstall | w_divstall;
      hz.stallE = w_divstall;
      hz.flushE = (w_lwstall | w_branchstall) & ~w_divstall;
      hz.flushM = w_divstall;
    end
  end

  // Divide sequencer: IDLE -> RUN for DIV_CYCLES cycles, aborted by an exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else if (hz.excM) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= hz.div_startE ? S_RUN : S_IDLE;
          r_cnt   <= 6'd0;
        end
        S_RUN: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
          end else begin
            r_state <= S_RUN;
            r_cnt   <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, divide/exception/reset
// sequences and randomized traffic against a behavioural reference model.
module tb_hazard_unit;
  localparam int DIV = 32;

  logic clk;
  logic resetn;
  hazard_unit_if hz ();

  hazard_unit #(.DIV_CYCLES(DIV)) dut (.clk(clk), .resetn(resetn), .hz(hz));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Model of the divider: cycles still to spend in the busy phase (0 = idle).
  int m_left;
  always @(posedge clk or negedge resetn) begin
    if (!resetn)                 m_left <= 0;
    else if (hz.excM)            m_left <= 0;
    else if (m_left > 0)         m_left <= m_left - 1;
    else if (hz.div_startE)      m_left <= DIV;
    else                         m_left <= 0;
  end

  function automatic logic [16:0] dut_vec();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
            hz.flushD, hz.flushE, hz.flushM, hz.flushW,
            hz.forwardAD, hz.forwardBD, hz.forwardAE, hz.forwardBE,
            hz.div_busy, hz.div_done};
  endfunction

  function automatic bit uses(input int src, input int dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic int fwd_e(input int src);
    if (hz.regwriteM && uses(src, int'(hz.writeregM))) return 2;
    if (hz.regwriteW && uses(src, int'(hz.writeregW))) return 1;
    return 0;
  endfunction

  function automatic logic [16:0] model_vec();
    bit lw, br, dv, st_f, st_e, fl_d, fl_e, fl_m, fl_w, f_ad, f_bd;
    int rs, rt, we, wm;
    rs = int'(hz.rsD); rt = int'(hz.rtD); we = int'(hz.writeregE); wm = int'(hz.writeregM);
    lw = hz.memtoregE && (uses(rs, we) || uses(rt, we));
    br = hz.branchD && ((hz.regwriteE && (uses(rs, we) || uses(rt, we))) ||
                        (hz.memtoregM && (uses(rs, wm) || uses(rt, wm))));
    dv = (m_left == 0 && hz.div_startE) || (m_left > 1);
    if (hz.excM) begin
      st_f = 0; st_e = 0; fl_d = 1; fl_e = 1; fl_m = 1; fl_w = 1;
    end else begin
      st_f = lw || br || dv; st_e = dv; fl_d = 0; fl_e = (lw || br) && !dv; fl_m = dv; fl_w = 0;
    end
    f_ad = hz.regwriteM && uses(rs, wm);
    f_bd = hz.regwriteM && uses(rt, wm);
    return {st_f, st_f, st_e, 1'b0, 1'b0, fl_d, fl_e, fl_m, fl_w, f_ad, f_bd,
            2'(fwd_e(int'(hz.rsE))), 2'(fwd_e(int'(hz.rtE))),
            m_left > 0, m_left == 1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0; hz.branchD = 1'b0;
    hz.div_startE = 1'b0; hz.excM = 1'b0;
  endtask

  // Run one full divide from idle and measure the stall window.
  task automatic run_divide(input string tag);
    int st_cnt, busy_cnt, flm_cnt, done_cnt, done_at, first_busy;
    st_cnt = 0; busy_cnt = 0; flm_cnt = 0; done_cnt = 0; done_at = -1; first_busy = -1;
    for (int i = 0; i < DIV + 8; i++) begin
      @(negedge clk);
      hz.div_startE = (i < DIV) ? 1'b1 : 1'b0;
      #1;
      chk({tag, "_model"}, 32'(dut_vec()), 32'(model_vec()));
      if (hz.stallE) st_cnt++;
      if (hz.flushM) flm_cnt++;
      if (hz.div_busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (hz.div_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    chk({tag, "_stallE_cycles"}, 32'(st_cnt), 32'(DIV));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DIV));
    chk({tag, "_flushM_cycles"}, 32'(flm_cnt), 32'(DIV));
    chk({tag, "_first_busy"}, 32'(first_busy), 32'd1);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_at"}, 32'(done_at), 32'(DIV));
  endtask

  typedef struct {
    logic [4:0]  rsD, rtD, rsE, rtE, wE, wM, wW;
    logic        rgE, rgM, rgW, mtE, mtM, brD, exc;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [16:0] act;

  initial begin
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_0000};
    tbl[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'b11000_0100_00_0000};
    tbl[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_0000};
    tbl[3]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_1000};
    tbl[4]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_0100};
    tbl[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_0000};
    tbl[6]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'b11000_0100_00_0000};
    tbl[7]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'b00000_0000_01_0000};
    tbl[8]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 15'b00000_1111_00_0000};
    tbl[9]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'b00000_0000_00_0001};
    tbl[10] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'b11000_0100_10_0000};
    tbl[11] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'b11000_0100_00_0000};

    clear_inputs();
    resetn = 1'b0;
    #12;
    act = dut_vec();
    chk("reset_outputs", 32'(act), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors, divider idle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hz.rsD = tbl[i].rsD; hz.rtD = tbl[i].rtD; hz.rsE = tbl[i].rsE; hz.rtE = tbl[i].rtE;
      hz.writeregE = tbl[i].wE; hz.writeregM = tbl[i].wM; hz.writeregW = tbl[i].wW;
      hz.regwriteE = tbl[i].rgE; hz.regwriteM = tbl[i].rgM; hz.regwriteW = tbl[i].rgW;
      hz.memtoregE = tbl[i].mtE; hz.memtoregM = tbl[i].mtM; hz.branchD = tbl[i].brD;
      hz.excM = tbl[i].exc; hz.div_startE = 1'b0;
      #1;
      act = dut_vec();
      chk($sformatf("vec%0d", i), 32'(act[16:2]), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(act[1:0]), 32'd0);
    end

    // Full divide; start held high through RUN to show it is ignored
    @(negedge clk);
    clear_inputs();
    run_divide("div");

    // Divide started while a load-use hazard is present: no E bubble
    @(negedge clk);
    hz.memtoregE = 1'b1; hz.writeregE = 5'd5; hz.rsD = 5'd5; hz.div_startE = 1'b1;
    #1;
    act = dut_vec();
    chk("div_lw_stallF_stallE_flushE", 32'({act[16], act[14], act[10]}), 32'b110);
    for (int i = 0; i < DIV + 2; i++) begin
      @(negedge clk);
      hz.div_startE = 1'b0;
      #1;
      chk("div_lw_model", 32'(dut_vec()), 32'(model_vec()));
    end
    clear_inputs();

    // Exception at cnt=10 aborts the divide
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hz.div_startE = 1'b1;
      hz.excM = (i == 11) ? 1'b1 : 1'b0;
      #1;
      chk("exc_model", 32'(dut_vec()), 32'(model_vec()));
    end
    act = dut_vec();
    chk("exc_stalls", 32'(act[16:12]), 32'd0);
    chk("exc_flushes", 32'(act[11:8]), 32'hF);
    chk("exc_busy_during", 32'(act[1]), 32'd1);
    @(negedge clk);
    hz.excM = 1'b0; hz.div_startE = 1'b0;
    #1;
    act = dut_vec();
    chk("exc_after_busy_done", 32'(act[1:0]), 32'd0);
    run_divide("exc_restart");

    // Asynchronous reset between edges while running
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hz.div_startE = 1'b1;
    end
    #3;
    chk("arst_pre_busy", 32'(hz.div_busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("arst_busy_drop", 32'(hz.div_busy), 32'd0);
    @(negedge clk);
    hz.div_startE = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    run_divide("arst_restart");

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hz.rsD = 5'($urandom_range(0, 3)); hz.rtD = 5'($urandom_range(0, 3));
      hz.rsE = 5'($urandom_range(0, 3)); hz.rtE = 5'($urandom_range(0, 3));
      hz.writeregE = 5'($urandom_range(0, 3)); hz.writeregM = 5'($urandom_range(0, 3));
      hz.writeregW = 5'($urandom_range(0, 3));
      hz.regwriteE = 1'($urandom); hz.regwriteM = 1'($urandom); hz.regwriteW = 1'($urandom);
      hz.memtoregE = 1'($urandom); hz.memtoregM = 1'($urandom); hz.branchD = 1'($urandom);
      hz.div_startE = ($urandom_range(0, 15) == 0);
      hz.excM = ($urandom_range(0, 59) == 0);
      #1;
      chk("rand", 32'(dut_vec()), 32'(model_vec()));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
